// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and width helpers for lock_controller.
// Contents: state_t (IDLE/UNLOCKED/LOCKOUT), STATE_W, fail_cnt_w().
package lock_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;
  function automatic int fail_cnt_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction
endpackage

// File: rtl/lock_controller_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle TICK every DIV cycles.
// Ports: CLK clock, RST_N async active-low reset, CLR sync prescaler clear,
//        TICK one-cycle pulse when the prescaler reaches DIV-1.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign TICK = cnt == W'(DIV - 1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else if (CLR || TICK) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/lock_controller.sv
// lock_controller: turns pass/fail verdicts into a timed unlock, counts
// consecutive failures and enforces a timed lockout with a blinking alarm.
// Ports: CLK, RST_N (async active-low), PASS_IN/FAIL_IN verdict levels,
//        DOOR_OPEN, LOCKED_OUT, ALARM, ENTRY_EN, FAIL_CNT, STATE_DBG.
module lock_controller
  import lock_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int UNLOCK_TICKS  = 3000,
  parameter int LOCKOUT_TICKS = 10000,
  parameter int BLINK_TICKS   = 250,
  parameter int MAX_FAILS     = 3
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                PASS_IN,
  input  logic                                FAIL_IN,
  output logic                                DOOR_OPEN,
  output logic                                LOCKED_OUT,
  output logic                                ALARM,
  output logic                                ENTRY_EN,
  output logic [fail_cnt_w(MAX_FAILS)-1:0]    FAIL_CNT,
  output logic [STATE_W-1:0]                  STATE_DBG
);
  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int FW  = fail_cnt_w(MAX_FAILS);
  localparam int TW  = $clog2((UNLOCK_TICKS > LOCKOUT_TICKS ? UNLOCK_TICKS : LOCKOUT_TICKS) + 1);
  localparam int BW  = $clog2(BLINK_TICKS + 1);
  state_t state, nxt;
  logic pass_d, fail_d, pass_ev, fail_ev, fail_last;
  logic tick, entry, expire, alarm;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  assign pass_ev   = PASS_IN & ~pass_d;
  assign fail_ev   = FAIL_IN & ~fail_d;
  assign fail_last = int'(fcnt) + 1 == MAX_FAILS;
  assign expire    = tick && tcnt == '0;
  // any state change restarts the shared timer, including recovery from code 3
  assign entry     = nxt != state;
  tick_gen #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST_N(RST_N),
    .CLR  (entry),
    .TICK (tick)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:              nxt = fail_ev ? (fail_last ? LOCKOUT : IDLE) : pass_ev ? UNLOCKED : IDLE;
      UNLOCKED, LOCKOUT: nxt = expire ? IDLE : state;
      default:           nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      pass_d <= 1'b1;
      fail_d <= 1'b1;
      fcnt   <= '0;
      tcnt   <= '0;
      bcnt   <= '0;
      alarm  <= 1'b0;
    end else begin
      pass_d <= PASS_IN;
      fail_d <= FAIL_IN;
      if (state == IDLE && fail_ev) fcnt <= fail_last ? '0 : fcnt + 1'b1;
      else if (state == IDLE && pass_ev) fcnt <= '0;
      if (entry) tcnt <= nxt == LOCKOUT ? TW'(LOCKOUT_TICKS - 1) : TW'(UNLOCK_TICKS - 1);
      else if (tick && tcnt != '0) tcnt <= tcnt - 1'b1;
      // alarm phase is loaded on every entry but only shown in LOCKOUT
      if (entry) begin
        bcnt  <= BW'(BLINK_TICKS - 1);
        alarm <= 1'b1;
      end else if (tick) begin
        bcnt  <= bcnt == '0 ? BW'(BLINK_TICKS - 1) : bcnt - 1'b1;
        alarm <= bcnt == '0 ? ~alarm : alarm;
      end
    end
  always_comb begin
    DOOR_OPEN  = state == UNLOCKED;
    LOCKED_OUT = state == LOCKOUT;
    ENTRY_EN   = state == IDLE;
    ALARM      = alarm & (state == LOCKOUT);
    FAIL_CNT   = fcnt;
    STATE_DBG  = state;
  end
endmodule
